// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - fetch/decode handshake bundle between if_id_stage and its surroundings
interface if_id_stage_if;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic [31:0] instr_id;
  logic [31:0] pc4_id;
  logic        valid_id;
  logic        bubble;
  logic        stall;

  modport master (
    input  imem_instr, branch_taken, branch_target, jump, jump_target,
           idex_memread, idex_rt,
    output pc, instr_id, pc4_id, valid_id, bubble, stall
  );

  modport slave (
    output imem_instr, branch_taken, branch_target, jump, jump_target,
           idex_memread, idex_rt,
    input  pc, instr_id, pc4_id, valid_id, bubble, stall
  );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC, IF/ID register and load-use hazard logic; optional counters under IF_ID_PERF_EN
module if_id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  if_id_stage_if.master bus
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   flush_count,
  output logic [31:0]   fetch_count
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        stall, redirect, advance, flush;
  logic        rt_match;
  logic [31:0] pc_plus4, target;

  assign pc_plus4 = pc_q + 32'd4;
  assign rt_match = (bus.idex_rt == instr_q[25:21]) | (bus.idex_rt == instr_q[20:16]);
  assign stall    = valid_q & bus.idex_memread & (bus.idex_rt != 5'd0) & rt_match;
  // ID operands are stale during a stall, so redirects wait until it clears
  assign redirect = ~stall & valid_q & (bus.branch_taken | bus.jump);
  assign target   = bus.branch_taken ? bus.branch_target : bus.jump_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    advance = 1'b0;
    flush   = 1'b0;
    case (state_q)
      BOOT: begin
        advance = 1'b1;
        state_d = RUN;
      end
      RUN, STALL: begin
        if (stall) begin
          state_d = STALL;
        end else begin
          state_d = RUN;
          flush   = redirect;
          advance = ~redirect;
        end
      end
      default: state_d = BOOT;
    endcase
    if (advance) begin
      pc_d    = pc_plus4;
      instr_d = bus.imem_instr;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end else if (flush) begin
      pc_d    = target;
      instr_d = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end
  end

  // Falling edge keeps this register in step with ID/EX
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= PC_RESET;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_ID_PERF_EN
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
      fetch_count  <= 32'd0;
    end else begin
      if (stall && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (flush && flush_count != 32'hFFFF_FFFF)  flush_count  <= flush_count + 32'd1;
      if (advance && fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

  assign bus.pc       = pc_q;
  assign bus.instr_id = instr_q;
  assign bus.pc4_id   = pc4_q;
  assign bus.valid_id = valid_q;
  assign bus.bubble   = stall | ~valid_q;
  assign bus.stall    = stall;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard bench for if_id_stage (IF_ID_PERF_EN optional)
module tb_if_id_stage;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_id_stage_if bus ();

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cycles, flush_count, fetch_count;
`endif

  if_id_stage #(.PC_RESET(PC_RESET), .NOP_WORD(NOP_WORD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .fetch_count  (fetch_count)
`endif
  );

  // rs is always 8 so an idex_rt of 8 is a guaranteed load-use hit
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return {6'h23, 5'd8, a[6:2], a[17:2]};
  endfunction

  assign bus.imem_instr = imem_f(bus.pc);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] sc;
    logic [31:0] fl;
    logic [31:0] fe;
  } exp_t;

  exp_t sbq[$];

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_sc, m_fl, m_fe;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic m_fetch();
    m_instr = imem_f(m_pc);
    m_pc4   = m_pc + 32'd4;
    m_pc    = m_pc + 32'd4;
    m_valid = 1'b1;
    m_fe    = sat_inc(m_fe);
  endtask

  task automatic m_flush(input logic [31:0] t);
    m_pc    = t;
    m_instr = NOP_WORD;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
    m_fl    = sat_inc(m_fl);
  endtask

  task automatic cycle(input logic rst, input logic bt, input logic [31:0] bta,
                       input logic j, input logic [31:0] ja,
                       input logic mr, input logic [4:0] rt);
    logic m_stall;
    exp_t e, got;
    @(posedge clk);
    rst_n              = ~rst;
    bus.branch_taken   = bt;
    bus.branch_target  = bta;
    bus.jump           = j;
    bus.jump_target    = ja;
    bus.idex_memread   = mr;
    bus.idex_rt        = rt;
    #1;
    m_stall = m_valid && mr && (rt != 5'd0) &&
              (rt == m_instr[25:21] || rt == m_instr[20:16]);
    if (!rst) begin
      check("stall", {31'd0, bus.stall}, {31'd0, m_stall});
      check("bubble", {31'd0, bus.bubble}, {31'd0, m_stall | ~m_valid});
    end
    if (rst) begin
      m_pc = PC_RESET; m_instr = NOP_WORD; m_pc4 = 32'd0; m_valid = 1'b0;
      m_sc = 32'd0; m_fl = 32'd0; m_fe = 32'd0;
    end else if (!m_valid) begin
      m_fetch();
    end else if (m_stall) begin
      m_sc = sat_inc(m_sc);
    end else if (bt) begin
      m_flush(bta);
    end else if (j) begin
      m_flush(ja);
    end else begin
      m_fetch();
    end
    e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, sc: m_sc, fl: m_fl, fe: m_fe};
    sbq.push_back(e);
    @(negedge clk);
    #1;
    got = sbq.pop_front();
    check("pc", bus.pc, got.pc);
    check("instr_id", bus.instr_id, got.instr);
    check("pc4_id", bus.pc4_id, got.pc4);
    check("valid_id", {31'd0, bus.valid_id}, {31'd0, got.valid});
`ifdef IF_ID_PERF_EN
    check("stall_cycles", stall_cycles, got.sc);
    check("flush_count", flush_count, got.fl);
    check("fetch_count", fetch_count, got.fe);
`endif
  endtask

  task automatic run(input logic mr, input logic [4:0] rt);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, mr, rt);
  endtask

  initial begin
    m_pc = PC_RESET; m_instr = NOP_WORD; m_pc4 = 32'd0; m_valid = 1'b0;
    m_sc = 32'd0; m_fl = 32'd0; m_fe = 32'd0;
    bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
    bus.jump = 1'b0; bus.jump_target = 32'd0;
    bus.idex_memread = 1'b0; bus.idex_rt = 5'd0;

    // reset must win over a live branch and hazard
    cycle(1'b1, 1'b1, 32'h80, 1'b1, 32'h90, 1'b1, 5'd8);
    cycle(1'b1, 1'b1, 32'h80, 1'b0, 32'd0, 1'b0, 5'd0);
    check("rst_bubble", {31'd0, bus.bubble}, 32'd1);

    run(1'b0, 5'd0);
    repeat (3) run(1'b0, 5'd0);

    // load-use, then $0 never stalls
    run(1'b1, 5'd8);
    run(1'b0, 5'd0);
    run(1'b1, 5'd0);

    cycle(1'b0, 1'b1, 32'h40, 1'b0, 32'd0, 1'b0, 5'd0);
    run(1'b0, 5'd0);
    run(1'b0, 5'd0);

    // branch during a two-cycle stall is dropped, then re-asserted
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 5'd8);
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 5'd8);
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 5'd0);
    run(1'b0, 5'd0);

    // branch beats jump
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 5'd0);
    run(1'b0, 5'd0);

    // wrap
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0);
    run(1'b0, 5'd0);
    run(1'b0, 5'd0);

    for (int i = 0; i < 60; i++) begin
      logic [4:0] rt;
      case ($urandom_range(0, 2))
        0:       rt = 5'd0;
        1:       rt = 5'd8;
        default: rt = 5'($urandom);
      endcase
      cycle(1'b0, $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 5) == 0, $urandom,
            1'($urandom), rt);
    end

    // reset in the middle of a stall
    run(1'b0, 5'd0);
    run(1'b0, 5'd0);
    run(1'b1, 5'd8);
    run(1'b1, 5'd8);
    cycle(1'b1, 1'b1, 32'h500, 1'b0, 32'd0, 1'b1, 5'd8);
    run(1'b0, 5'd0);
    run(1'b0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
